load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage initiator that turns RV32 load/store requests (byte address, funct3) into accesses on the word-only data-memory port: mem_read, mem_write, 6-bit word address, 32-bit data in/out.
- Handles sub-word accesses by read-modify-write and, when enabled, misaligned accesses by splitting them across two words.
- Sits between the core's MEM stage and the data memory; the core stalls while req_ready is low.

Parameters:
ADDR_W, 6, memory word-address width; word index = addr[ADDR_W+1:2], upper address bits ignored (alias).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data (low bytes used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, extended; 0 for stores/faults
resp_fault  output  1  access not performed; valid with resp_valid
mem_read  output  1  memory read enable; memory data is combinational same cycle
mem_write  output  1  memory write enable; written at rising edge
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0; mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
- mem_read and mem_write are gated by ~rst combinationally, so no write occurs on a reset edge.
- Accept: at an edge with req_valid && req_ready. Latch we, funct3, addr, wdata. req_valid while busy is ignored.
- Decode:
  - Size: funct3[1:0] 00=1 B, 01=2 B, 10=4 B.
  - Loads: legal funct3 = 000, 001, 010, 100, 101.
  - Stores: legal funct3 = 000, 001, 010.
  - Anything else is illegal.
  - off = addr[1:0]; span = (off + size > 4).
- States:
  - IDLE: waits for acceptance. Illegal funct3 -> DONE with fault. Otherwise -> RD0.
  - RD0: mem_read=1, mem_addr=w0. Capture mem_rdata into buf0. span -> RD1; else store -> WR0; else load -> DONE.
  - RD1: mem_read=1, mem_addr=w0+1 (mod 2^ADDR_W; word 63 wraps to 0). Capture buf1. Store -> WR0; load -> DONE.
  - WR0: mem_write=1, mem_addr=w0, mem_wdata = merged low word. span -> WR1; else DONE.
  - WR1: mem_write=1, mem_addr=w0+1 (wrapped), mem_wdata = merged high word. -> DONE.
  - DONE: resp_valid=1 for one cycle. -> IDLE.
- resp_rdata and resp_fault are registered. They update on entry to DONE and hold until the next response.
- Load extract: V = {buf1, buf0} >> (8*off). Take low 8/16/32 bits.
  - 000/001: sign-extend.
  - 100/101: zero-extend.
  - 010: as is.
- Store merge (little-endian):
  - mask = (1 << 8*size) - 1, shifted left 8*off into 64 bits.
  - new = ({buf1, buf0} & ~mask) | ((wdata & size mask) << 8*off).
  - Bytes outside mask are unchanged.
- Every store does a read first, including SW.
- Latency in cycles from acceptance edge to resp_valid:
  - aligned load: 2
  - aligned store: 3
  - spanning load: 3
  - spanning store: 5
  - fault: 1
- mem_addr and mem_wdata are 0 in IDLE and DONE. mem_wdata is 0 in RD states.
- Reset mid-operation: no memory write at that edge; next cycle is IDLE with all outputs at reset values. A partially completed spanning store may leave only word0 written.

Optional Feature:
LSU_MISALIGNED_EN
- Defined: span accesses are split as above. resp_fault is set only for illegal funct3.
- Undefined: a request is faulted when any of these holds:
  - span is true;
  - a halfword access has off=1 or off=3;
  - a word access has off!=0.
  A faulted request goes IDLE -> DONE with resp_fault=1, resp_rdata=0, and no mem_read/mem_write. RD1 and WR1 are unreachable.

Test Plan:
- Preload mem[0]=3, mem[1]=7. LW addr 0x4 -> resp_valid 2 cycles after accept, resp_rdata=0x00000007, resp_fault=0.
- mem[2]=0x11223344. SB addr 0x9, wdata 0xAB -> mem[2]=0x1122AB44. Then LB 0x9 -> 0xFFFFFFAB; LBU 0x9 -> 0x000000AB.
- mem[0]=3, mem[1]=7. SH addr 0x3, wdata 0xBEEF:
  - EN: states RD0, RD1, WR0, WR1, DONE (5 cycles); mem[0]=0xEF000003, mem[1]=0x000000BE.
  - Not EN: 1 cycle; resp_fault=1; memory unchanged.
- EN: mem[63]=0xAABBCCDD, mem[0]=3. LW addr 0xFE -> RD1 mem_addr=0 (wrap), resp_rdata=0x0003AABB.
- SW addr 0x8, wdata 0xDEADBEEF; assert rst during the WR0 cycle -> mem_write=0 that cycle, mem[2] unchanged, next cycle req_ready=1 and resp_valid=0.
- Load with funct3=011 (also store with funct3=100) -> resp_fault=1 one cycle after accept, resp_rdata=0, mem_read and mem_write never asserted.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps RV32 byte-addressed loads/stores onto a word-only memory port.
// Two-word misaligned accesses are split when LSU_MISALIGNED_EN is defined, else faulted.
module load_store_unit #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_fault_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StDone} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [1:0]          off_q;
    logic [ADDR_W-1:0]   w0_q;
    logic [ADDR_W-1:0]   w1;
    logic [31:0]         wdata_q;
    logic                span_q;
    logic [31:0]         buf0_q, buf1_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                fault_q, fault_d;

    logic [2:0]          req_size;
    logic                req_span;
    logic                req_legal;
    logic                req_fault;
    logic                unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_W+2];

    always_comb begin
        unique case (req_funct3_i[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    assign req_span = ({1'b0, req_addr_i[1:0]} + req_size) > 3'd4;

    always_comb begin
        if (req_we_i) begin
            req_legal = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b11);
        end else begin
            req_legal = (req_funct3_i[1:0] != 2'b11) && !(req_funct3_i[2] && req_funct3_i[1]);
        end
    end

`ifdef LSU_MISALIGNED_EN
    assign req_fault = !req_legal;
`else
    assign req_fault = !req_legal || req_span
                     || ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                     || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`endif

    assign w1 = w0_q + ADDR_W'(1);

    // Datapath: the load view sees data arriving this cycle so it can be registered on entry to DONE.
    logic [5:0]  shamt;
    logic [31:0] size_mask;
    logic [63:0] cur_words;
    logic [31:0] load_word;
    logic [31:0] load_val;
    logic [63:0] byte_mask;
    logic [63:0] wdata_shifted;
    logic [63:0] merged;

    assign shamt     = {off_q, 3'b000};
    assign cur_words = {(state_q == StRd1) ? mem_rdata_i : buf1_q,
                        (state_q == StRd0) ? mem_rdata_i : buf0_q};
    assign load_word = 32'(cur_words >> shamt);

    always_comb begin
        unique case (funct3_q[1:0])
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign byte_mask     = {32'h0, size_mask} << shamt;
    assign wdata_shifted = {32'h0, wdata_q & size_mask} << shamt;
    assign merged        = ({buf1_q, buf0_q} & ~byte_mask) | wdata_shifted;

    always_comb begin
        unique case (funct3_q)
            3'b000:  load_val = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_val = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_val = {24'h0, load_word[7:0]};
            3'b101:  load_val = {16'h0, load_word[15:0]};
            default: load_val = load_word;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            w0_q     <= '0;
            wdata_q  <= 32'h0;
            span_q   <= 1'b0;
            buf0_q   <= 32'h0;
            buf1_q   <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            if (state_q == StIdle && req_valid_i) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                off_q    <= req_addr_i[1:0];
                w0_q     <= req_addr_i[ADDR_W+1:2];
                wdata_q  <= req_wdata_i;
                span_q   <= req_span;
                buf1_q   <= 32'h0;
            end
            if (state_q == StRd0) buf0_q <= mem_rdata_i;
            if (state_q == StRd1) buf1_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = 32'h0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_fault) begin
                        state_d = StDone;
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                    end else begin
                        state_d = StRd0;
                    end
                end
            end
            StRd0: begin
                mem_read_o = !rst_i;
                mem_addr_o = w0_q;
                if (span_q) begin
                    state_d = StRd1;
                end else if (we_q) begin
                    state_d = StWr0;
                end else begin
                    state_d = StDone;
                    rdata_d = load_val;
                    fault_d = 1'b0;
                end
            end
            StRd1: begin
                mem_read_o = !rst_i;
                mem_addr_o = w1;
                if (we_q) begin
                    state_d = StWr0;
                end else begin
                    state_d = StDone;
                    rdata_d = load_val;
                    fault_d = 1'b0;
                end
            end
            StWr0: begin
                mem_write_o = !rst_i;
                mem_addr_o  = w0_q;
                mem_wdata_o = merged[31:0];
                if (span_q) begin
                    state_d = StWr1;
                end else begin
                    state_d = StDone;
                    rdata_d = 32'h0;
                    fault_d = 1'b0;
                end
            end
            StWr1: begin
                mem_write_o = !rst_i;
                mem_addr_o  = w1;
                mem_wdata_o = merged[63:32];
                state_d     = StDone;
                rdata_d     = 32'h0;
                fault_d     = 1'b0;
            end
            StDone: begin
                resp_valid_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_rdata_o = rdata_q;
    assign resp_fault_o = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, misaligned/reset sequences and random
// requests checked against a byte-level memory model. Honours LSU_MISALIGNED_EN.
module tb_load_store_unit;

`ifdef LSU_MISALIGNED_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(6)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_fault_o (resp_fault),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Word memory with a backdoor port for preloading.
    logic [31:0] mem [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr = 6'd0;
    logic [31:0] bd_data = 32'h0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    logic [7:0] refb [256];
    logic [2:0] ld_f3 [5];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refword(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = w[5:0];
        bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int i = 0; i < 4; i++) refb[w*4+i] = d[8*i+:8];
    endtask

    // Byte-level reference: applies the access to refb and returns the expected response.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                         output int lat);
        int size;
        int off;
        bit sp;
        bit legal;
        bit mis;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(a[1:0]);
        sp    = (off + size) > 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = !MisEn && (sp || (size == 2 && off % 2 == 1) || (size == 4 && off != 0));
        rd    = 32'h0;
        flt   = !legal || mis;
        lat   = 1;
        if (flt) return;
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
            int ba;
            ba = (int'(a[7:0]) + i) % 256;
            if (we) refb[ba] = wd[8*i+:8];
            else v[8*i+:8] = refb[ba];
        end
        if (!we) begin
            case (f3)
                3'd0:    rd = {{24{v[7]}}, v[7:0]};
                3'd1:    rd = {{16{v[15]}}, v[15:0]};
                default: rd = v;
            endcase
        end
        lat = we ? (sp ? 5 : 3) : (sp ? 3 : 2);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat, output int nrd, output int nwr,
                          output logic [5:0] last_ra);
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        lat = 1;
        nrd = 0;
        nwr = 0;
        last_ra = 6'd0;
        while (!resp_valid && lat < 12) begin
            if (mem_read) begin
                nrd++;
                last_ra = mem_addr;
            end
            if (mem_write) nwr++;
            // Noise on the request port while busy must be ignored.
            req_valid = 1'($urandom);
            req_we = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr = $urandom;
            req_wdata = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        chk("resp_seen", 32'(resp_valid), 32'd1);
        rd = resp_rdata;
        flt = resp_fault;
        @(posedge clk);
        #1;
        chk("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    logic [31:0] rd, mrd;
    logic        flt, mflt;
    int          lat, mlat, nrd, nwr;
    logic [5:0]  last_ra;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra, rwd;

    initial begin
        vecs[0]  = '{1'b0, 3'b010, 32'h4,   32'h0,        32'h0000_0007, 1'b0, 4'd2};
        vecs[1]  = '{1'b1, 3'b000, 32'h9,   32'hFFFF_FFAB, 32'h0,         1'b0, 4'd3};
        vecs[2]  = '{1'b0, 3'b000, 32'h9,   32'h0,        32'hFFFF_FFAB, 1'b0, 4'd2};
        vecs[3]  = '{1'b0, 3'b100, 32'h9,   32'h0,        32'h0000_00AB, 1'b0, 4'd2};
        vecs[4]  = '{1'b0, 3'b010, 32'h8,   32'h0,        32'h1122_AB44, 1'b0, 4'd2};
        vecs[5]  = '{1'b1, 3'b001, 32'hA,   32'hDEAD_5678, 32'h0,         1'b0, 4'd3};
        vecs[6]  = '{1'b0, 3'b001, 32'hA,   32'h0,        32'h0000_5678, 1'b0, 4'd2};
        vecs[7]  = '{1'b0, 3'b001, 32'h8,   32'h0,        32'hFFFF_AB44, 1'b0, 4'd2};
        vecs[8]  = '{1'b0, 3'b101, 32'h8,   32'h0,        32'h0000_AB44, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 3'b010, 32'h108, 32'h0,        32'h5678_AB44, 1'b0, 4'd2};
        vecs[10] = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h0,         1'b1, 4'd1};
        vecs[11] = '{1'b1, 3'b100, 32'h0,   32'h1234,     32'h0,         1'b1, 4'd1};
        vecs[12] = '{1'b0, 3'b110, 32'h4,   32'h0,        32'h0,         1'b1, 4'd1};
        vecs[13] = '{1'b1, 3'b011, 32'h4,   32'h55,       32'h0,         1'b1, 4'd1};
        vecs[14] = '{1'b1, 3'b010, 32'hC,   32'hCAFE_F00D, 32'h0,         1'b0, 4'd3};
        vecs[15] = '{1'b0, 3'b010, 32'hC,   32'h0,        32'hCAFE_F00D, 1'b0, 4'd2};
        vecs[16] = '{1'b0, 3'b000, 32'hF,   32'h0,        32'hFFFF_FFCA, 1'b0, 4'd2};
        vecs[17] = '{1'b0, 3'b001, 32'h0,   32'h0,        32'h0000_0003, 1'b0, 4'd2};
        ld_f3[0] = 3'd0;
        ld_f3[1] = 3'd1;
        ld_f3[2] = 3'd2;
        ld_f3[3] = 3'd4;
        ld_f3[4] = 3'd5;

        for (int w = 0; w < 64; w++) poke(w, 32'h0);
        poke(0, 32'h3);
        poke(1, 32'h7);
        poke(2, 32'h1122_3344);

        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_fault", 32'(resp_fault), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mflt, mlat);
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat, nrd, nwr,
                   last_ra);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].fault));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].fault) chk($sformatf("vec%0d_memacc", i), 32'(nrd + nwr), 32'd0);
        end

        // SH spanning words 0/1.
        model(1'b1, 3'b001, 32'h3, 32'h0000_BEEF, mrd, mflt, mlat);
        do_req(1'b1, 3'b001, 32'h3, 32'h0000_BEEF, rd, flt, lat, nrd, nwr, last_ra);
`ifdef LSU_MISALIGNED_EN
        chk("sh3_fault", 32'(flt), 32'd0);
        chk("sh3_latency", 32'(lat), 32'd5);
        chk("sh3_reads", 32'(nrd), 32'd2);
        chk("sh3_writes", 32'(nwr), 32'd2);
        chk("sh3_mem0", mem[0], 32'hEF00_0003);
        chk("sh3_mem1", mem[1], 32'h0000_00BE);
        poke(63, 32'hAABB_CCDD);
        poke(0, 32'h3);
        model(1'b0, 3'b010, 32'hFE, 32'h0, mrd, mflt, mlat);
        do_req(1'b0, 3'b010, 32'hFE, 32'h0, rd, flt, lat, nrd, nwr, last_ra);
        chk("wrap_rdata", rd, 32'h0003_AABB);
        chk("wrap_latency", 32'(lat), 32'd3);
        chk("wrap_rd1_addr", 32'(last_ra), 32'd0);
        chk("wrap_fault", 32'(flt), 32'd0);
`else
        chk("sh3_fault", 32'(flt), 32'd1);
        chk("sh3_latency", 32'(lat), 32'd1);
        chk("sh3_memacc", 32'(nrd + nwr), 32'd0);
        chk("sh3_mem0", mem[0], 32'h0000_0003);
        chk("sh3_mem1", mem[1], 32'h0000_0007);
        model(1'b0, 3'b010, 32'h2, 32'h0, mrd, mflt, mlat);
        do_req(1'b0, 3'b010, 32'h2, 32'h0, rd, flt, lat, nrd, nwr, last_ra);
        chk("lw2_fault", 32'(flt), 32'd1);
        chk("lw2_rdata", rd, 32'h0);
        model(1'b0, 3'b001, 32'h1, 32'h0, mrd, mflt, mlat);
        do_req(1'b0, 3'b001, 32'h1, 32'h0, rd, flt, lat, nrd, nwr, last_ra);
        chk("lh1_fault", 32'(flt), 32'd1);
        chk("lh1_memacc", 32'(nrd + nwr), 32'd0);
`endif

        // Reset asserted during WR0 of an aligned SW must suppress the write.
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h8;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_wr0", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_write_gated", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem2", mem[2], refword(2));
        rst = 1'b0;

        repeat (250) begin
            rwe = 1'($urandom);
            if ($urandom_range(0, 3) != 0) rf3 = rwe ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            else rf3 = 3'($urandom);
            ra = $urandom;
            rwd = $urandom;
            model(rwe, rf3, ra, rwd, mrd, mflt, mlat);
            do_req(rwe, rf3, ra, rwd, rd, flt, lat, nrd, nwr, last_ra);
            chk($sformatf("rnd_rdata we=%0d f3=%0d a=%h", rwe, rf3, ra), rd, mrd);
            chk($sformatf("rnd_fault we=%0d f3=%0d a=%h", rwe, rf3, ra), 32'(flt), 32'(mflt));
            chk($sformatf("rnd_latency we=%0d f3=%0d a=%h", rwe, rf3, ra), 32'(lat), 32'(mlat));
            if (mflt) chk("rnd_fault_memacc", 32'(nrd + nwr), 32'd0);
        end

        for (int w = 0; w < 64; w++) chk($sformatf("final_mem%0d", w), mem[w], refword(w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
